// File: rtl/regpair_sequencer.sv
// Control sequencer for the 8085 register-pair array: turns one accepted command into
// the timed pair-select, byte read/write and dreg latch/write-back strobe pattern.
module regpair_sequencer #(
    parameter int WAIT_MAX = 16,
    parameter int CW       = $clog2(WAIT_MAX)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [2:0] cmd_pair,
    input  logic       byte_valid,
    input  logic       abort,
    output logic       bc_rw,
    output logic       de_rw,
    output logic       hl_rw,
    output logic       wz_rw,
    output logic       pc_rw,
    output logic       sp_rw,
    output logic       lreg_wr,
    output logic       rreg_wr,
    output logic       lreg_rd,
    output logic       rreg_rd,
    output logic       dreg_wr,
    output logic       dreg_rd,
    output logic       inc_dec,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // Handshake: a command is taken on a rising edge where cmd_valid and cmd_ready are
    // both high; cmd_ready is high exactly when the sequencer is idle.

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_LDPAIR = 3'd1;
    localparam logic [2:0] OP_STPAIR = 3'd2;
    localparam logic [2:0] OP_INC    = 3'd3;
    localparam logic [2:0] OP_DEC    = 3'd4;
    localparam logic [2:0] OP_ADDR   = 3'd5;

    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_LO,
        S_LD_HI,
        S_ST_HI,
        S_ST_LO,
        S_ID_LAT,
        S_ID_WB,
        S_AD_LAT,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state, state_d;
    logic [2:0]    op_q, pair_q;
    logic [CW-1:0] cnt, cnt_d;
    logic          accept;
    logic          sel_en;
    logic [5:0]    sel;

    assign accept = cmd_valid && (state == S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            pair_q <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                op_q   <= cmd_op;
                pair_q <= cmd_pair;
            end
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    cnt_d = '0;
                    if (cmd_op >= 3'd6 || cmd_pair >= 3'd6) begin
                        state_d = S_ERR;
                    end else begin
                        unique case (cmd_op)
                            OP_NOP:         state_d = S_DONE;
                            OP_LDPAIR:      state_d = S_LD_LO;
                            OP_STPAIR:      state_d = S_ST_HI;
                            OP_INC, OP_DEC: state_d = S_ID_LAT;
                            OP_ADDR:        state_d = S_AD_LAT;
                            default:        state_d = S_ERR;
                        endcase
                    end
                end
            end
            // Both byte waits share one counter; byte_valid outranks the timeout.
            S_LD_LO, S_LD_HI: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (byte_valid) begin
                    cnt_d   = '0;
                    state_d = (state == S_LD_LO) ? S_LD_HI : S_DONE;
                end else if (cnt == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_ST_HI:  state_d = abort ? S_IDLE : S_ST_LO;
            S_ST_LO:  state_d = abort ? S_IDLE : S_DONE;
            S_ID_LAT: state_d = abort ? S_IDLE : S_ID_WB;
            S_ID_WB:  state_d = abort ? S_IDLE : S_DONE;
            S_AD_LAT: state_d = abort ? S_IDLE : S_DONE;
            S_DONE:   state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        sel_en    = 1'b0;
        lreg_wr   = 1'b0;
        rreg_wr   = 1'b0;
        lreg_rd   = 1'b0;
        rreg_rd   = 1'b0;
        dreg_wr   = 1'b0;
        dreg_rd   = 1'b0;
        inc_dec   = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        unique case (state)
            S_IDLE:   cmd_ready = 1'b1;
            S_LD_LO: begin
                sel_en  = 1'b1;
                rreg_wr = byte_valid && !abort;
            end
            S_LD_HI: begin
                sel_en  = 1'b1;
                lreg_wr = byte_valid && !abort;
            end
            S_ST_HI: begin
                sel_en  = 1'b1;
                lreg_rd = !abort;
            end
            S_ST_LO: begin
                sel_en  = 1'b1;
                rreg_rd = !abort;
            end
            S_ID_LAT, S_AD_LAT: begin
                sel_en  = 1'b1;
                dreg_wr = !abort;
            end
            S_ID_WB: begin
                sel_en  = 1'b1;
                dreg_rd = !abort;
                inc_dec = (op_q == OP_INC);
            end
            S_DONE:   done = 1'b1;
            S_ERR:    err  = 1'b1;
            default:  cmd_ready = 1'b0;
        endcase
    end

    // pair_q is always 0..5 while sel_en is high; invalid pairs go straight to ERR.
    assign sel   = sel_en ? (6'd1 << pair_q) : 6'd0;
    assign bc_rw = sel[0];
    assign de_rw = sel[1];
    assign hl_rw = sel[2];
    assign wz_rw = sel[3];
    assign pc_rw = sel[4];
    assign sp_rw = sel[5];
    assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_regpair_sequencer.sv
// Scoreboard bench for regpair_sequencer: a command-level model predicts the per-cycle
// output vector, the driver replays the matching byte_valid/abort schedule, a monitor compares.
module tb_regpair_sequencer;

    localparam int WAIT_MAX = 4;
    localparam logic [1:0] K_BUSY = 2'd0;
    localparam logic [1:0] K_DONE = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;
    // {cmd_ready, busy, done, err, sel[5:0], lw, rw, lr, rr, dw, dr, inc_dec}
    localparam logic [16:0] IDLE_VEC = 17'h10000;
    localparam logic [16:0] ALL      = '1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [2:0] cmd_pair = '0;
    logic       byte_valid = 1'b0;
    logic       abort = 1'b0;
    logic       bc_rw, de_rw, hl_rw, wz_rw, pc_rw, sp_rw;
    logic       lreg_wr, rreg_wr, lreg_rd, rreg_rd, dreg_wr, dreg_rd, inc_dec;
    logic       busy, done, err;

    regpair_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_pair(cmd_pair),
        .byte_valid(byte_valid), .abort(abort),
        .bc_rw(bc_rw), .de_rw(de_rw), .hl_rw(hl_rw), .wz_rw(wz_rw), .pc_rw(pc_rw), .sp_rw(sp_rw),
        .lreg_wr(lreg_wr), .rreg_wr(rreg_wr), .lreg_rd(lreg_rd), .rreg_rd(rreg_rd),
        .dreg_wr(dreg_wr), .dreg_rd(dreg_rd), .inc_dec(inc_dec),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [16:0] act;
    assign act = {cmd_ready, busy, done, err, sp_rw, pc_rw, wz_rw, hl_rw, de_rw, bc_rw,
                  lreg_wr, rreg_wr, lreg_rd, rreg_rd, dreg_wr, dreg_rd, inc_dec};

    int   n_vec = 0;
    int   n_bad = 0;
    logic mon_en = 1'b0;

    logic [16:0] exp_q[$];
    logic [1:0]  in_q[$];
    logic [1:0]  sk[$];
    logic [6:0]  ss[$];
    logic        sb[$];

    task automatic check(input string name, input logic [16:0] got, input logic [16:0] want,
                         input logic [16:0] mask);
        n_vec++;
        if ((got & mask) !== (want & mask)) begin
            n_bad++;
            $display("FAIL %s: got %05h want %05h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic add_slot(input logic [1:0] kind, input logic [6:0] strb, input logic bv);
        sk.push_back(kind);
        ss.push_back(strb);
        sb.push_back(bv);
    endtask

    // Byte wait of w idle cycles then the byte; w >= WAIT_MAX means the byte never comes.
    task automatic add_wait(input int w, input logic [6:0] strb, output logic timed_out);
        int n;
        n = (w < WAIT_MAX) ? w : WAIT_MAX;
        for (int i = 0; i < n; i++) add_slot(K_BUSY, 7'h00, 1'b0);
        timed_out = (w >= WAIT_MAX);
        if (timed_out) add_slot(K_ERR, 7'h00, 1'($urandom));
        else           add_slot(K_BUSY, strb, 1'b1);
    endtask

    // Reference model: list the cycles c1.. of one command, then apply an abort at slot ab_at.
    task automatic build(input int op, input int pair, input int lo, input int hi, input int ab_at);
        logic [5:0]  sel;
        logic [16:0] v;
        logic        to;
        logic        ab;
        sk.delete(); ss.delete(); sb.delete();
        sel = '0;
        if (pair < 6) sel[pair] = 1'b1;
        if (op >= 6 || pair >= 6) begin
            add_slot(K_ERR, 7'h00, 1'($urandom));
        end else begin
            case (op)
                0: add_slot(K_DONE, 7'h00, 1'($urandom));
                1: begin
                    add_wait(lo, 7'h20, to);
                    if (!to) begin
                        add_wait(hi, 7'h40, to);
                        if (!to) add_slot(K_DONE, 7'h00, 1'($urandom));
                    end
                end
                2: begin
                    add_slot(K_BUSY, 7'h10, 1'($urandom));
                    add_slot(K_BUSY, 7'h08, 1'($urandom));
                    add_slot(K_DONE, 7'h00, 1'($urandom));
                end
                3, 4: begin
                    add_slot(K_BUSY, 7'h04, 1'($urandom));
                    add_slot(K_BUSY, (op == 3) ? 7'h03 : 7'h02, 1'($urandom));
                    add_slot(K_DONE, 7'h00, 1'($urandom));
                end
                default: begin
                    add_slot(K_BUSY, 7'h04, 1'($urandom));
                    add_slot(K_DONE, 7'h00, 1'($urandom));
                end
            endcase
        end
        for (int k = 0; k < sk.size(); k++) begin
            ab = (k == ab_at);
            case (sk[k])
                K_BUSY:  v = {4'b0100, sel, ab ? 7'h00 : ss[k]};
                K_DONE:  v = {4'b0110, 6'h00, 7'h00};
                default: v = {4'b0101, 6'h00, 7'h00};
            endcase
            exp_q.push_back(v);
            in_q.push_back({sb[k], ab});
            if (ab && sk[k] == K_BUSY) break;
        end
    endtask

    task automatic issue(input int op, input int pair, input int lo, input int hi, input int ab_at);
        logic [1:0] x;
        build(op, pair, lo, hi, ab_at);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_op     = op[2:0];
        cmd_pair   = pair[2:0];
        byte_valid = 1'($urandom);
        abort      = 1'($urandom);
        while (in_q.size() > 0) begin
            x = in_q.pop_front();
            @(negedge clk);
            cmd_valid  = 1'($urandom);
            cmd_op     = 3'($urandom);
            cmd_pair   = 3'($urandom);
            byte_valid = x[1];
            abort      = x[0];
        end
        if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            cmd_valid  = 1'b0;
            byte_valid = 1'($urandom);
            abort      = 1'($urandom);
        end
    endtask

    // Monitor: every busy cycle consumes one expected vector; idle cycles must look idle.
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en && rst) begin
                if (busy) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_busy: got %05h want idle (t=%0t)", act, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("busy_cycle", act, e, e[1] ? ALL : ~17'h1);
                    end
                end else begin
                    check("idle_cycle", act, IDLE_VEC, ALL);
                end
            end
        end
    end

    initial begin
        int op, pair;
        // Reset state, then release.
        @(negedge clk);
        #1 check("reset_state", act, IDLE_VEC, ALL);
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;

        issue(2, 2, 0, 0, -1);                 // STPAIR HL
        issue(1, 0, 2, 0, -1);                 // LDPAIR BC, two idle waits then bytes
        issue(3, 5, 0, 0, -1);                 // INC SP
        issue(4, 5, 0, 0, -1);                 // DEC SP
        issue(1, 1, WAIT_MAX, 0, -1);          // LDPAIR DE, low-byte timeout
        issue(1, 3, 1, WAIT_MAX, -1);          // high-byte timeout after a low write
        issue(1, 4, WAIT_MAX - 1, WAIT_MAX - 1, -1); // byte on the last wait cycle wins
        issue(0, 7, 0, 0, -1);                 // invalid pair
        issue(6, 0, 0, 0, -1);                 // reserved op
        issue(2, 2, 0, 0, 0);                  // abort in c1 of STPAIR
        issue(1, 0, 0, 0, 1);                  // abort together with the high byte
        issue(5, 4, 0, 0, 1);                  // abort during DONE is ignored
        issue(0, 1, 0, 0, -1);                 // NOP

        for (int n = 0; n < 60; n++) begin
            op   = $urandom_range(0, 7);
            pair = ($urandom_range(0, 5) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
            issue(op, pair, $urandom_range(0, WAIT_MAX + 1), $urandom_range(0, WAIT_MAX + 1),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1);
        end

        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drained: got %0d left want 0", exp_q.size());
            exp_q.delete();
        end

        // Asynchronous reset in the middle of the high-byte wait.
        mon_en = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_pair = 3'd0; byte_valid = 1'b0; abort = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0; byte_valid = 1'b1;
        #1 check("rst_ld_lo", act, {4'b0100, 6'h01, 7'h20}, ALL);
        @(negedge clk);
        byte_valid = 1'b0;
        #1 check("rst_ld_hi", act, {4'b0100, 6'h01, 7'h00}, ALL);
        #2 rst = 1'b0;
        #1 check("rst_async", act, IDLE_VEC, ALL);
        cmd_valid = 1'b1; byte_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1 check("rst_held", act, IDLE_VEC, ALL);
        end
        @(negedge clk);
        rst = 1'b1; cmd_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            byte_valid = 1'($urandom); abort = 1'($urandom);
            #1 check("post_rst_idle", act, IDLE_VEC, ALL);
        end
        mon_en = 1'b1;
        issue(1, 2, 1, 1, -1);
        issue(2, 5, 0, 0, -1);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL final_drain: got %0d left want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
